// File: rtl/fft_cooley_tukey_helpers_sine_table_builder_if.sv
// Handshake bundle for the sine table builder:
// quarter-wave sample input and packed table output.
interface fft_cooley_tukey_helpers_sine_table_builder_if #(
  parameter int BIT_WIDTH = 32,
  parameter int SIZE_FFT  = 8
);
  logic [BIT_WIDTH-1:0]          recv_msg;
  logic                          recv_val;
  logic                          recv_rdy;
  logic [SIZE_FFT*BIT_WIDTH-1:0] send_msg;
  logic                          send_val;
  logic                          send_rdy;

  modport master (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val
  );

  modport slave (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val
  );
endinterface

// File: rtl/fft_cooley_tukey_helpers_sine_table_builder.sv
// Expands quarter-wave sine samples by symmetry
// into a packed full-period table for twiddles.
module fft_cooley_tukey_helpers_sine_table_builder #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int SIZE_FFT   = 8
) (
  input logic clk,
  input logic reset,
  fft_cooley_tukey_helpers_sine_table_builder_if.slave bus
);
  localparam int N  = SIZE_FFT;
  localparam int Q  = N / 4;
  localparam int JW = $clog2(Q + 1);

  localparam logic [BIT_WIDTH-1:0] MIN =
    {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0] MAX = ~MIN;

  if (N < 4 || (N & (N - 1)) != 0 ||
      DECIMAL_PT >= BIT_WIDTH) begin : g_bad_param
    $error("sine table builder: bad parameters");
  end

  typedef enum logic {
    LOAD,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [JW-1:0]        r_j;
  logic [JW-1:0]        w_j_nxt;
  logic                 w_hs;
  logic                 w_last;
  logic [BIT_WIDTH-1:0] w_neg;

  assign w_hs   = bus.recv_val & (r_state == LOAD);
  assign w_last = (r_j == JW'(Q));

  // Negation of the most negative code clips to max.
  assign w_neg = (bus.recv_msg == MIN) ? MAX
                                       : -bus.recv_msg;

  assign bus.recv_rdy = (r_state == LOAD);
  assign bus.send_val = (r_state == HOLD);

  // Next state and sample counter.
  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    unique case (r_state)
      LOAD: begin
        if (w_hs) begin
          if (w_last) begin
            w_state_nxt = HOLD;
            w_j_nxt     = '0;
          end else begin
            w_j_nxt = r_j + JW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.send_rdy) begin
          w_state_nxt = LOAD;
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
      r_j     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
    end
  end

  // Entry k mirrors quarter sample KJ, negated in
  // the second half-period.
  for (genvar k = 0; k < N; k++) begin : g_ent
    localparam int KJ =
      (k <= Q)     ? k :
      (k <= 2 * Q) ? 2 * Q - k :
      (k <= 3 * Q) ? k - 2 * Q :
                     N - k;
    localparam bit NEG = (k > 2 * Q);

    logic [BIT_WIDTH-1:0] r_ent;

    // Rewrite this entry when its sample arrives.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_ent <= '0;
      end else if (w_hs && r_j == JW'(KJ)) begin
        r_ent <= NEG ? w_neg : bus.recv_msg;
      end
    end

    assign bus.send_msg[(N-1-k)*BIT_WIDTH +: BIT_WIDTH] =
      r_ent;
  end
endmodule
